cmp_result_filter: RTL
======================

CMP_RESULT_FILTER -- requirements
Module: cmp_result_filter

Interface
REQ-001 The block SHALL have parameter STABLE_CNT, default 4, the number of consecutive identical valid samples needed to commit a result (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all flops update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, which qualifies the comparator flags in the current cycle.
REQ-005 The block SHALL have port a_less_b, input, 1, the upstream comparator "a<b" flag.
REQ-006 The block SHALL have port a_great_b, input, 1, the upstream comparator "a>b" flag.
REQ-007 The block SHALL have port a_equal_b, input, 1, the upstream comparator "a==b" flag.
REQ-008 The block SHALL have port state_o, output, 2, the committed relation: UNKNOWN=0, LESS=1, EQUAL=2, GREAT=3.
REQ-009 The block SHALL have port state_valid, output, 1, asserted whenever state_o != UNKNOWN.
REQ-010 The block SHALL have port change_pulse, output, 1, a one-cycle pulse on each state_o change.
REQ-011 The block SHALL have port err_pulse, output, 1, a one-cycle pulse on each illegal valid sample.
REQ-012 The block SHALL have port change_cnt, output, 8, the saturating count of committed changes (present only with CMP_CHANGE_CNT_EN).

Function
REQ-013 A sample SHALL be legal when exactly one of the three flags is 1; it SHALL be encoded LESS/EQUAL/GREAT.
REQ-014 Cycles with in_valid=0 SHALL hold all state; gaps SHALL NOT break a run.
REQ-015 Internal regs: cand (2b), run (4b, saturates at STABLE_CNT).
REQ-016 On a legal valid sample equal to cand, run SHALL increment (saturating); otherwise cand<=sample and run<=1.
REQ-017 When the updated run equals STABLE_CNT and the sample differs from state_o, state_o SHALL take the sample at that same edge, and change_pulse SHALL be 1 for the following cycle only.
REQ-018 Latency: with STABLE_CNT=N, state_o SHALL change on the edge that accepts the Nth consecutive matching sample; STABLE_CNT=1 gives a one-edge commit.
REQ-019 An illegal valid sample (zero or more than one flag set) SHALL set err_pulse for one cycle, set cand<=UNKNOWN and run<=0, and hold state_o.
REQ-020 A run reaching STABLE_CNT on a value equal to state_o SHALL produce no pulse and no state change.
REQ-021 The transition UNKNOWN->X SHALL count as a change.
REQ-022 change_pulse and err_pulse SHALL never both be asserted in the same cycle.

Reset
REQ-023 rst_n low SHALL asynchronously force state_o=UNKNOWN, cand=UNKNOWN, run=0, state_valid=0, change_pulse=0, err_pulse=0 and change_cnt=0.
REQ-024 Reset asserted mid-run SHALL discard the run; after release a full STABLE_CNT samples SHALL be required to commit.

Configuration
REQ-025 Macro CMP_CHANGE_CNT_EN defined: the change_cnt port SHALL exist and increment on every change_pulse, saturating at 255.
REQ-026 Macro CMP_CHANGE_CNT_EN undefined: the change_cnt port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package cmp_filter_pkg SHALL hold the 2-bit relation typedef, the UNKNOWN/LESS/EQUAL/GREAT constants and the counter width constant.
REQ-028 Sub-module cmp_flag_decode SHALL be combinational and SHALL produce a legal flag and a 2-bit code from the three flags; all sequential logic SHALL live in cmp_result_filter.

Verification
REQ-029 Test: STABLE_CNT=4; apply 4 valid LESS samples (100 on less/great/equal) -> state_o=1 after the 4th edge, one change_pulse, and change_cnt=1.
REQ-030 Test: apply LESS x3, then GREAT x1, then LESS x3 -> no commit; state_o stays 0 and no pulses occur.
REQ-031 Test: apply EQUAL x2, then in_valid=0 for 5 cycles, then EQUAL x2 -> state_o=2 on the 4th valid edge.
REQ-032 Test: apply flags 110, then 000, with valid -> two err_pulses, run cleared, state_o held; 4 further GREAT samples -> state_o=3.
REQ-033 Test: commit GREAT, then apply 10 more GREAT samples -> no extra change_pulse and change_cnt unchanged.
REQ-034 Test: assert rst_n low after 2 LESS samples, release, then apply 3 LESS -> state_o=0; the 4th LESS -> state_o=1. With the macro undefined, the same tests SHALL pass minus the change_cnt checks.

Source files
------------

// File: rtl/cmp_filter_pkg.sv
// cmp_filter_pkg: relation encoding and counter width shared by the comparator result filter.
package cmp_filter_pkg;
    typedef logic [1:0] rel_t;
    localparam rel_t UNKNOWN = 2'd0;
    localparam rel_t LESS    = 2'd1;
    localparam rel_t EQUAL   = 2'd2;
    localparam rel_t GREAT   = 2'd3;
    localparam int   CNT_W   = 8;
endpackage

// File: rtl/cmp_flag_decode.sv
// cmp_flag_decode: one-hot check and relation encoding of the three comparator flags.
module cmp_flag_decode
    import cmp_filter_pkg::*;
(
    input  logic a_less_b,
    input  logic a_great_b,
    input  logic a_equal_b,
    output logic legal,
    output rel_t code
);
    // Odd parity minus the all-ones case leaves exactly-one-set.
    assign legal = (a_less_b ^ a_great_b ^ a_equal_b) & ~(a_less_b & a_great_b & a_equal_b);
    assign code  = a_less_b ? LESS : a_equal_b ? EQUAL : a_great_b ? GREAT : UNKNOWN;
endmodule

// File: rtl/cmp_result_filter.sv
// cmp_result_filter: debounces comparator flags, committing a relation after STABLE_CNT matching samples.
// Optional change counter enabled by defining CMP_CHANGE_CNT_EN.
module cmp_result_filter
    import cmp_filter_pkg::*;
#(
    parameter int STABLE_CNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic a_less_b,
    input  logic a_great_b,
    input  logic a_equal_b,
    output rel_t state_o,
    output logic state_valid,
    output logic change_pulse,
    output logic err_pulse
`ifdef CMP_CHANGE_CNT_EN
    ,
    output logic [CNT_W-1:0] change_cnt
`endif
);
    localparam logic [3:0] STABLE = 4'(STABLE_CNT);
    logic       legal;
    rel_t       code;
    rel_t       cand;
    logic [3:0] run;
    logic [3:0] run_nxt;
    logic       commit;

    cmp_flag_decode u_dec (
        .a_less_b (a_less_b),
        .a_great_b(a_great_b),
        .a_equal_b(a_equal_b),
        .legal    (legal),
        .code     (code)
    );

    always_comb begin
        run_nxt = (code == cand) ? ((run == STABLE) ? run : run + 4'd1) : 4'd1;
        commit  = in_valid && legal && (run_nxt == STABLE) && (code != state_o);
    end

    assign state_valid = state_o != UNKNOWN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_o      <= UNKNOWN;
            cand         <= UNKNOWN;
            run          <= 4'd0;
            change_pulse <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            change_pulse <= commit;
            err_pulse    <= in_valid && !legal;
            if (in_valid) begin
                cand <= legal ? code : UNKNOWN;
                run  <= legal ? run_nxt : 4'd0;
            end
            if (commit)
                state_o <= code;
        end
    end

`ifdef CMP_CHANGE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            change_cnt <= '0;
        else if (commit && change_cnt != '1)
            change_cnt <= change_cnt + CNT_W'(1);
    end
`endif
endmodule
